// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake between the MEM-stage pipeline and the load/store controller.
// The pipeline side drives the request; the controller answers with a one-cycle response pulse.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32 load/store controller in front of a word-wide, single-port data memory with registered read.
// Sub-word stores are done as read-modify-write; every output is decoded from registered state.
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         clk,
    input  logic                         RESET,
    lsu_mem_ctrl_if.slave                bus,
    output logic [$clog2(MEM_DEPTH)-1:0] dm_addr,
    output logic [31:0]                  dm_write_data,
    output logic                         dm_mem_write,
    output logic                         dm_mem_read,
    input  logic [31:0]                  dm_dout
);

    localparam int DM_AW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(4 * MEM_DEPTH);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_EXT,
        RMW_RD,
        RMW_MRG,
        ST_WR,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         funct3_q;
    logic [1:0]         offset_q;
    logic               err_q;
    logic [DM_AW-1:0]   waddr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;

    logic               acc_illegal;
    logic               acc_misaligned;
    logic               acc_range;
    logic               acc_err;
    logic               accept;

    // Selects the addressed lane out of a memory word and extends it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  offset,
                                                input logic [31:0] word);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'd0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'd0, lane_h};
            default: result = word;
        endcase
        return result;
    endfunction

    // Replaces only the addressed byte/half lane of the old word; other lanes pass through untouched.
    function automatic logic [31:0] store_merge(input logic [2:0]  funct3,
                                                input logic [1:0]  offset,
                                                input logic [31:0] old_word,
                                                input logic [31:0] new_data);
        logic [31:0] result;
        result = old_word;
        case (funct3)
            F3_B: begin
                case (offset)
                    2'd0:    result[7:0]   = new_data[7:0];
                    2'd1:    result[15:8]  = new_data[7:0];
                    2'd2:    result[23:16] = new_data[7:0];
                    default: result[31:24] = new_data[7:0];
                endcase
            end
            F3_H: begin
                if (offset[1]) result[31:16] = new_data[15:0];
                else           result[15:0]  = new_data[15:0];
            end
            default: result = new_data;
        endcase
        return result;
    endfunction

    assign accept = (state_q == IDLE) && bus.req_valid;

    // Request checks feed only the registers below, never an output directly.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        acc_illegal    = 1'b1;
        acc_misaligned = 1'b0;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: acc_illegal = 1'b0;
            F3_BU, F3_HU:     acc_illegal = bus.req_we;
            default:          acc_illegal = 1'b1;
        endcase
        case (bus.req_funct3)
            F3_H, F3_HU: acc_misaligned = bus.req_addr[0];
            F3_W:        acc_misaligned = |bus.req_addr[1:0];
            default:     acc_misaligned = 1'b0;
        endcase
        acc_range = {1'b0, bus.req_addr} >= ADDR_LIMIT;
        acc_err   = acc_illegal || acc_misaligned || acc_range;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        dm_mem_read  = 1'b0;
        dm_mem_write = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (acc_err)                  state_d = RESP;
                    else if (!bus.req_we)         state_d = LD_RD;
                    else if (bus.req_funct3 == F3_W) state_d = ST_WR;
                    else                          state_d = RMW_RD;
                end
            end
            LD_RD: begin
                dm_mem_read = 1'b1;
                state_d     = LD_EXT;
            end
            LD_EXT:  state_d = RESP;
            RMW_RD: begin
                dm_mem_read = 1'b1;
                state_d     = RMW_MRG;
            end
            RMW_MRG: state_d = ST_WR;
            ST_WR: begin
                dm_mem_write = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers; a reset in ST_WR still lets the memory take that cycle's write.
    always_ff @(posedge clk) begin
        if (RESET) begin
            funct3_q <= '0;
            offset_q <= '0;
            err_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        funct3_q <= bus.req_funct3;
                        offset_q <= bus.req_addr[1:0];
                        err_q    <= acc_err;
                        waddr_q  <= bus.req_addr[DM_AW+1:2];
                        wdata_q  <= bus.req_wdata;
                        rdata_q  <= '0;
                    end
                end
                LD_EXT:  rdata_q <= load_extend(funct3_q, offset_q, dm_dout);
                RMW_MRG: wdata_q <= store_merge(funct3_q, offset_q, dm_dout, wdata_q);
                default: ;
            endcase
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign dm_addr        = waddr_q;
    assign dm_write_data  = wdata_q;

endmodule
